symbol_aligner: RTL and testbench
=================================

SYMBOL_ALIGNER -- requirements
Module: symbol_aligner

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 20, symbol-pair width; COMMA_LOCK_CNT, default 3, consecutive aligned commas needed to lock.
REQ-002 SHALL have ports, clock and reset first:
- cdr_clk_i  in  1  recovered clock; single clock domain.
- cdr_arst_n_i  in  1  reset; asynchronous assert, active-low.
- raw_data_i  in  20  unaligned deserialized bits; bit 0 is first received.
- raw_vld_i  in  1  raw_data_i valid this cycle.
- cfg_align_en_i  in  1  1 = align, 0 = bypass.
- cfg_loss_thr_i  in  4  consecutive misaligned commas that force relock; 0 is treated as 1.
- data_out_o  out  20  aligned symbol pair; feeds the elastic buffer data input.
- data_vld_o  out  1  aligned data valid; feeds the elastic buffer write enable.
- lock_o  out  1  aligner in LOCKED.
- align_offset_o  out  5  current bit offset, 0..19.
- realign_evt_pulse_o  out  1  1-cycle pulse on LOCKED->HUNT.
- stat_cnt_realign_o  out  16  relock counter (see Configuration).

Function
REQ-003 SHALL register prev_q <= raw_data_i on each raw_vld_i cycle, forming window w[39:0] = {raw_data_i, prev_q}.
REQ-004 Comma at offset k (0..19): w[k+9:k] == 10'b0011111010 or 10'b1100000101.
REQ-005 When several commas are present, the lowest k SHALL be the detected offset. A comma "matches" a stored offset when k mod 10 == stored mod 10.
REQ-006 All state and pointer updates SHALL occur only on raw_vld_i=1; with raw_vld_i=0, everything holds and data_vld_o=0.
REQ-007 FSM states and transitions:
- HUNT: on a comma -> VERIFY with offset=k, cnt=1.
- VERIFY, matching comma: cnt++. When cnt reaches COMMA_LOCK_CNT -> LOCKED.
- VERIFY, non-matching comma: stay in VERIFY with offset=k, cnt=1.
- VERIFY, no comma: hold.
REQ-008 LOCKED, miss counting:
- A comma is present and none matches: miss++.
- A matching comma is present: miss=0.
- No comma: miss holds.
- miss reaches max(cfg_loss_thr_i,1): -> HUNT, miss=0, realign_evt_pulse_o=1 for one cycle.
REQ-009 LOCKED output path: data_out_o <= w[offset+19:offset] registered; data_vld_o <= raw_vld_i; latency is 1 cycle from the raw_vld_i beat.
REQ-010 Outside LOCKED with cfg_align_en_i=1: data_vld_o=0 and data_out_o holds.
REQ-011 cfg_align_en_i=0: FSM forced to HUNT, offset=0, counters cleared; data_out_o <= prev_q and data_vld_o <= raw_vld_i (bypass).
REQ-012 Deassertion of cfg_align_en_i mid-lock SHALL take effect the next cycle and SHALL NOT pulse realign_evt_pulse_o.
REQ-013 lock_o and align_offset_o SHALL be registered and reflect the current state and offset.
REQ-014 cnt and miss SHALL saturate and never wrap.

Reset
REQ-015 On cdr_arst_n_i=0: state=HUNT; prev_q, offset, cnt, miss, data_out_o, data_vld_o, lock_o, realign_evt_pulse_o and stat_cnt_realign_o all 0.
REQ-016 Reset mid-lock SHALL drop lock_o and data_vld_o immediately, asynchronously.

Configuration
REQ-017 Macro SYMBOL_ALIGNER_STATS_EN:
- Defined: stat_cnt_realign_o increments by 1 on each LOCKED->HUNT event and wraps at 16'hFFFF.
- Undefined: no counter logic; stat_cnt_realign_o tied to 0. Port list is unchanged.

Structure
REQ-018 Shared package eb_pkg SHALL hold: K28.5 constants COMMA_RDN/COMMA_RDP, the align_state_e typedef (HUNT, VERIFY, LOCKED) and the default DATA_WIDTH.
REQ-019 Sub-module comma_detect SHALL be combinational: 40-bit window in, comma_found and lowest-offset (5 bits) out. The FSM and shifter stay in symbol_aligner.

Verification
REQ-020 Stream with comma 0011111010 at bit offset 7, repeated 3 times, thr=2 -> lock_o=1 on the 3rd comma beat, align_offset_o=7, data_out_o[9:0]=comma thereafter, latency 1.
REQ-021 Locked at 7, then 2 commas at offset 12 with thr=2 -> after the 2nd: lock_o=0, realign_evt_pulse_o one cycle, stat_cnt_realign_o=1 (macro on) or 0 (macro off).
REQ-022 Locked, then 1 misaligned comma followed by an aligned comma with thr=2 -> stays LOCKED, miss cleared.
REQ-023 Commas at offsets 3 and 13 in the same window -> offset=3 chosen; offset-13 commas count as matches.
REQ-024 raw_vld_i toggling 1010 during VERIFY -> lock reached after exactly 3 valid comma beats; data_vld_o=0 on idle cycles.
REQ-025 cfg_align_en_i=0 with raw 20'h5A5A5 -> data_out_o=20'h5A5A5 one beat later, lock_o=0; reset asserted mid-lock -> all outputs 0 immediately.

Source files
------------

// File: rtl/eb_pkg.sv
// Shared definitions for the receive path: K28.5 comma codes, aligner states
// and the default symbol-pair width.
package eb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 20;

    // 10-bit comma patterns as they appear in the window, bit 0 received first.
    localparam logic [9:0] COMMA_RDN = 10'b0011111010;
    localparam logic [9:0] COMMA_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    // Offsets never exceed 19, so one conditional subtract gives the symbol phase.
    function automatic logic [4:0] offset_mod10(input logic [4:0] off);
        return (off >= 5'd10) ? (off - 5'd10) : off;
    endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational comma search over the two-word window; reports the lowest
// bit offset holding either K28.5 disparity pattern.
module comma_detect
    import eb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [2*DATA_WIDTH-1:0] window,
    output logic                    comma_found,
    output logic [4:0]              comma_offset
);

    // Scanning downwards lets the lowest matching offset overwrite the others.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        comma_found  = 1'b0;
        comma_offset = '0;
        for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
            if ((window[k +: 10] == COMMA_RDN) || (window[k +: 10] == COMMA_RDP)) begin
                comma_found  = 1'b1;
                comma_offset = 5'(k);
            end
        end
    end

endmodule

// File: rtl/symbol_aligner.sv
// Comma-based symbol aligner: HUNT/VERIFY/LOCKED FSM plus barrel shifter.
// Optional relock statistics counter enabled by `define SYMBOL_ALIGNER_STATS_EN.
module symbol_aligner
    import eb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int COMMA_LOCK_CNT = 3
) (
    input  logic                  cdr_clk_i,
    input  logic                  cdr_arst_n_i,
    input  logic [DATA_WIDTH-1:0] raw_data_i,
    input  logic                  raw_vld_i,
    input  logic                  cfg_align_en_i,
    input  logic [3:0]            cfg_loss_thr_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  data_vld_o,
    output logic                  lock_o,
    output logic [4:0]            align_offset_o,
    output logic                  realign_evt_pulse_o,
    output logic [15:0]           stat_cnt_realign_o
);

    localparam logic [1:0] ST_HUNT   = HUNT;
    localparam logic [1:0] ST_VERIFY = VERIFY;
    localparam logic [1:0] ST_LOCKED = LOCKED;

    localparam int               CNT_W    = (COMMA_LOCK_CNT < 2) ? 1 : $clog2(COMMA_LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(COMMA_LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]              state_q, state_d;
    logic [4:0]              offset_q, offset_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [3:0]              miss_q, miss_d, miss_inc, loss_thr;
    logic                    realign_d;

    logic [DATA_WIDTH-1:0]   prev_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    data_vld_q;
    logic                    lock_q;
    logic                    realign_q;

    logic [2*DATA_WIDTH-1:0] window;
    logic                    comma_found;
    logic [4:0]              comma_offset;
    logic                    comma_match;

    assign window = {raw_data_i, prev_q};

    comma_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_comma_detect (
        .window       (window),
        .comma_found  (comma_found),
        .comma_offset (comma_offset)
    );

    assign comma_match = (offset_mod10(comma_offset) == offset_mod10(offset_q));
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign miss_inc    = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
    assign loss_thr    = (cfg_loss_thr_i == 4'd0) ? 4'd1 : cfg_loss_thr_i;

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        cnt_d     = cnt_q;
        miss_d    = miss_q;
        realign_d = 1'b0;

        if (!cfg_align_en_i) begin
            // Bypass overrides the FSM immediately, independent of raw_vld_i.
            state_d  = ST_HUNT;
            offset_d = '0;
            cnt_d    = '0;
            miss_d   = '0;
        end else if (raw_vld_i) begin
            case (state_q)
                ST_HUNT: begin
                    if (comma_found) begin
                        offset_d = comma_offset;
                        cnt_d    = CNT_W'(1);
                        state_d  = (COMMA_LOCK_CNT <= 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (comma_found) begin
                        if (comma_match) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= LOCK_CNT) begin
                                state_d = ST_LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            offset_d = comma_offset;
                            cnt_d    = CNT_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (comma_found) begin
                        if (comma_match) begin
                            miss_d = '0;
                        end else if (miss_inc >= loss_thr) begin
                            state_d   = ST_HUNT;
                            miss_d    = '0;
                            cnt_d     = '0;
                            realign_d = 1'b1;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    cnt_d   = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge cdr_clk_i or negedge cdr_arst_n_i) begin
        if (!cdr_arst_n_i) begin
            state_q    <= ST_HUNT;
            offset_q   <= '0;
            cnt_q      <= '0;
            miss_q     <= '0;
            prev_q     <= '0;
            data_q     <= '0;
            data_vld_q <= 1'b0;
            lock_q     <= 1'b0;
            realign_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            offset_q  <= offset_d;
            cnt_q     <= cnt_d;
            miss_q    <= miss_d;
            lock_q    <= (state_d == ST_LOCKED);
            realign_q <= realign_d;

            if (raw_vld_i) begin
                prev_q <= raw_data_i;
            end

            if (!cfg_align_en_i) begin
                data_vld_q <= raw_vld_i;
                if (raw_vld_i) begin
                    data_q <= prev_q;
                end
            end else begin
                data_vld_q <= raw_vld_i && (state_q == ST_LOCKED);
                if (raw_vld_i && (state_q == ST_LOCKED)) begin
                    data_q <= window[offset_q +: DATA_WIDTH];
                end
            end
        end
    end

`ifdef SYMBOL_ALIGNER_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge cdr_clk_i or negedge cdr_arst_n_i) begin
        if (!cdr_arst_n_i) begin
            stat_q <= '0;
        end else if (realign_d) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_cnt_realign_o = stat_q;
`else
    assign stat_cnt_realign_o = '0;
`endif

    assign data_out_o          = data_q;
    assign data_vld_o          = data_vld_q;
    assign lock_o              = lock_q;
    assign align_offset_o      = offset_q;
    assign realign_evt_pulse_o = realign_q;

endmodule

// File: tb/tb_symbol_aligner.sv
// Directed bench for symbol_aligner; expected values are hand-derived from the
// comma positions of each stimulus word.
module tb_symbol_aligner;

    logic        clk;
    logic        rst_n;
    logic [19:0] raw_data;
    logic        raw_vld;
    logic        align_en;
    logic [3:0]  loss_thr;
    logic [19:0] data_out;
    logic        data_vld;
    logic        lock;
    logic [4:0]  align_offset;
    logic        realign_pulse;
    logic [15:0] stat_cnt;

    int vectors;
    int miscompares;

    // Comma 0011111010 at window offset 7, entirely inside one word.
    localparam logic [19:0] C7  = 20'h07D00;
    // Comma at offset 12: low 8 bits at [19:12], top 2 bits (00) in next word.
    localparam logic [19:0] C12 = 20'hFA000;
    // Commas at offsets 3 and 13 when repeated back to back.
    localparam logic [19:0] W3  = 20'hF47D1;
    // Only the offset-13 comma when repeated.
    localparam logic [19:0] V13 = 20'hF4001;

`ifdef SYMBOL_ALIGNER_STATS_EN
    localparam logic [15:0] STAT_ONE = 16'd1;
`else
    localparam logic [15:0] STAT_ONE = 16'd0;
`endif

    symbol_aligner dut (
        .cdr_clk_i           (clk),
        .cdr_arst_n_i        (rst_n),
        .raw_data_i          (raw_data),
        .raw_vld_i           (raw_vld),
        .cfg_align_en_i      (align_en),
        .cfg_loss_thr_i      (loss_thr),
        .data_out_o          (data_out),
        .data_vld_o          (data_vld),
        .lock_o              (lock),
        .align_offset_o      (align_offset),
        .realign_evt_pulse_o (realign_pulse),
        .stat_cnt_realign_o  (stat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [19:0] d, input logic v);
        raw_data = d;
        raw_vld  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        raw_data    = '0;
        raw_vld     = 1'b0;
        align_en    = 1'b1;
        loss_thr    = 4'd2;

        #3;
        check("rst_lock", 32'(lock), 32'd0);
        check("rst_vld", 32'(data_vld), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_offset", 32'(align_offset), 32'd0);
        check("rst_pulse", 32'(realign_pulse), 32'd0);
        check("rst_stat", 32'(stat_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lock at offset 7: first word only fills prev, then 3 comma beats.
        step(C7, 1'b1);
        check("a_hunt_lock", 32'(lock), 32'd0);
        step(C7, 1'b1);
        check("a_verify_off", 32'(align_offset), 32'd7);
        check("a_verify_lock", 32'(lock), 32'd0);
        step(C7, 1'b1);
        check("a_cnt2_lock", 32'(lock), 32'd0);
        step(C7, 1'b1);
        check("a_locked", 32'(lock), 32'd1);
        check("a_locked_off", 32'(align_offset), 32'd7);
        check("a_lockbeat_vld", 32'(data_vld), 32'd0);
        step(C7, 1'b1);
        check("a_data", 32'(data_out), 32'h000FA);
        check("a_data_vld", 32'(data_vld), 32'd1);
        step(20'h0, 1'b0);
        check("a_idle_vld", 32'(data_vld), 32'd0);
        check("a_idle_hold", 32'(data_out), 32'h000FA);

        // One misaligned comma, then an aligned one, clears the miss count.
        step(C12, 1'b1);
        check("b_data_c7", 32'(data_out), 32'h000FA);
        step(C7, 1'b1);
        check("b_miss1_lock", 32'(lock), 32'd1);
        check("b_miss1_data", 32'(data_out), 32'h01F40);
        step(C7, 1'b1);
        check("b_realigned_data", 32'(data_out), 32'h000FA);
        step(C12, 1'b1);
        step(C7, 1'b1);
        check("b_miss_cleared", 32'(lock), 32'd1);
        check("b_no_pulse", 32'(realign_pulse), 32'd0);

        // Two consecutive offset-12 commas force relock.
        step(C7, 1'b1);
        step(C12, 1'b1);
        step(C12, 1'b1);
        check("c_miss1_lock", 32'(lock), 32'd1);
        check("c_miss1_pulse", 32'(realign_pulse), 32'd0);
        step(C12, 1'b1);
        check("c_unlock", 32'(lock), 32'd0);
        check("c_pulse", 32'(realign_pulse), 32'd1);
        check("c_stat", 32'(stat_cnt), 32'(STAT_ONE));
        check("c_last_vld", 32'(data_vld), 32'd1);
        check("c_last_data", 32'(data_out), 32'h01F40);
        step(C12, 1'b1);
        check("c_pulse_end", 32'(realign_pulse), 32'd0);
        check("c_hunt_off", 32'(align_offset), 32'd12);
        check("c_hunt_vld", 32'(data_vld), 32'd0);
        check("c_hunt_hold", 32'(data_out), 32'h01F40);

        // Lowest offset wins; offset 13 matches offset 3; threshold 0 acts as 1.
        do_reset();
        loss_thr = 4'd0;
        step(W3, 1'b1);
        check("d_hunt", 32'(lock), 32'd0);
        step(W3, 1'b1);
        check("d_off3", 32'(align_offset), 32'd3);
        step(W3, 1'b1);
        step(W3, 1'b1);
        check("d_locked", 32'(lock), 32'd1);
        step(V13, 1'b1);
        check("d_data_w3", 32'(data_out), 32'h3E8FA);
        step(V13, 1'b1);
        check("d_match13_lock", 32'(lock), 32'd1);
        check("d_data_v13", 32'(data_out), 32'h3E800);
        step(V13, 1'b1);
        check("d_match13_lock2", 32'(lock), 32'd1);
        step(C7, 1'b1);
        check("d_nocomma_lock", 32'(lock), 32'd1);
        check("d_nocomma_data", 32'(data_out), 32'h1E800);
        step(C7, 1'b1);
        check("d_thr0_unlock", 32'(lock), 32'd0);
        check("d_thr0_pulse", 32'(realign_pulse), 32'd1);
        check("d_thr0_stat", 32'(stat_cnt), 32'(STAT_ONE));

        // raw_vld toggling during VERIFY: only valid beats advance.
        loss_thr = 4'd2;
        step(C7, 1'b1);
        check("e_verify_off", 32'(align_offset), 32'd7);
        step(C12, 1'b0);
        check("e_idle1_vld", 32'(data_vld), 32'd0);
        step(C7, 1'b1);
        check("e_cnt2_lock", 32'(lock), 32'd0);
        step(C12, 1'b0);
        check("e_idle2_lock", 32'(lock), 32'd0);
        check("e_idle2_vld", 32'(data_vld), 32'd0);
        step(C7, 1'b1);
        check("e_locked", 32'(lock), 32'd1);
        step(20'h0, 1'b0);
        check("e_idle3_vld", 32'(data_vld), 32'd0);

        // Bypass entered mid-lock: no pulse, data is prev word one beat later.
        align_en = 1'b0;
        step(20'h5A5A5, 1'b1);
        check("f_unlock", 32'(lock), 32'd0);
        check("f_no_pulse", 32'(realign_pulse), 32'd0);
        check("f_off0", 32'(align_offset), 32'd0);
        check("f_data_prev", 32'(data_out), 32'(C7));
        check("f_vld", 32'(data_vld), 32'd1);
        step(20'h12345, 1'b1);
        check("f_data_5a", 32'(data_out), 32'h5A5A5);
        check("f_lock_off", 32'(lock), 32'd0);
        step(20'h0, 1'b0);
        check("f_idle_vld", 32'(data_vld), 32'd0);
        check("f_idle_hold", 32'(data_out), 32'h5A5A5);
        check("f_stat_kept", 32'(stat_cnt), 32'(STAT_ONE));

        // Asynchronous reset while locked clears outputs without a clock edge.
        align_en = 1'b1;
        do_reset();
        step(C7, 1'b1);
        step(C7, 1'b1);
        step(C7, 1'b1);
        step(C7, 1'b1);
        check("g_locked", 32'(lock), 32'd1);
        step(C7, 1'b1);
        check("g_vld_before", 32'(data_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        check("g_rst_lock", 32'(lock), 32'd0);
        check("g_rst_vld", 32'(data_vld), 32'd0);
        check("g_rst_data", 32'(data_out), 32'd0);
        check("g_rst_off", 32'(align_offset), 32'd0);
        check("g_rst_stat", 32'(stat_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
